// File: rtl/rf_wb_queue.sv
// Write-back queue for the register file's single write port: merges ALU and load results, retires one write per clock.
// Optional operand forwarding from pending entries is enabled with `define WB_FORWARD_EN.
module rf_wb_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        w_en,
    output logic [4:0]  w_addr,
    output logic [31:0] w_data,
    input  logic [4:0]  fwd_addr_a,
    output logic        fwd_hit_a,
    output logic [31:0] fwd_data_a,
    input  logic [4:0]  fwd_addr_b,
    output logic        fwd_hit_b,
    output logic [31:0] fwd_data_b,
    output logic        idle
);

    localparam logic [PTR_W:0] CNT_M1 = (PTR_W+1)'(DEPTH - 1);
    localparam logic [PTR_W:0] CNT_M2 = (PTR_W+1)'(DEPTH - 2);

    logic [4:0]       q_rd   [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic             mem_push;
    logic             alu_push;
    logic             pop;
    logic [PTR_W-1:0] alu_slot;

    // Ready is based on registered count only; a pop in the same cycle is not credited.
    assign mem_ready = (count <= CNT_M1);
    assign alu_ready = (count <= CNT_M2) || (!mem_valid && (count <= CNT_M1));

    // rd=0 transfers complete the handshake but never occupy a slot.
    assign mem_push = mem_valid && mem_ready && (mem_rd != 5'd0);
    assign alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
    assign pop      = (count != '0);
    assign alu_slot = tail + PTR_W'(mem_push);

    always_ff @(posedge clk) begin
        if (mem_push) begin
            q_rd[tail]   <= mem_rd;
            q_data[tail] <= mem_data;
        end
        if (alu_push) begin
            q_rd[alu_slot]   <= alu_rd;
            q_data[alu_slot] <= alu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            w_en   <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
        end else begin
            tail  <= tail + PTR_W'(mem_push) + PTR_W'(alu_push);
            count <= count + (PTR_W+1)'(mem_push) + (PTR_W+1)'(alu_push) - (PTR_W+1)'(pop);
            if (pop) begin
                w_en   <= 1'b1;
                w_addr <= q_rd[head];
                w_data <= q_data[head];
                head   <= head + 1'b1;
            end else begin
                w_en <= 1'b0;
            end
        end
    end

    assign idle = (count == '0) && !w_en;

`ifdef WB_FORWARD_EN
    // Scan oldest to youngest so later matches overwrite; the output register has lowest priority.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit_a  = 1'b0;
        fwd_data_a = '0;
        fwd_hit_b  = 1'b0;
        fwd_data_b = '0;
        idx        = '0;
        if (w_en && (w_addr == fwd_addr_a)) begin
            fwd_hit_a  = 1'b1;
            fwd_data_a = w_data;
        end
        if (w_en && (w_addr == fwd_addr_b)) begin
            fwd_hit_b  = 1'b1;
            fwd_data_b = w_data;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (((PTR_W+1)'(i) < count) && (q_rd[idx] == fwd_addr_a)) begin
                fwd_hit_a  = 1'b1;
                fwd_data_a = q_data[idx];
            end
            if (((PTR_W+1)'(i) < count) && (q_rd[idx] == fwd_addr_b)) begin
                fwd_hit_b  = 1'b1;
                fwd_data_b = q_data[idx];
            end
        end
        if (fwd_addr_a == 5'd0) begin
            fwd_hit_a  = 1'b0;
            fwd_data_a = '0;
        end
        if (fwd_addr_b == 5'd0) begin
            fwd_hit_b  = 1'b0;
            fwd_data_b = '0;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_addr_a, fwd_addr_b};
    assign fwd_hit_a  = 1'b0;
    assign fwd_data_a = '0;
    assign fwd_hit_b  = 1'b0;
    assign fwd_data_b = '0;
`endif

endmodule

// File: tb/tb_rf_wb_queue.sv
// Directed self-checking bench for rf_wb_queue; forwarding checks follow WB_FORWARD_EN.
module tb_rf_wb_queue;

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        w_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [4:0]  fwd_addr_a;
    logic        fwd_hit_a;
    logic [31:0] fwd_data_a;
    logic [4:0]  fwd_addr_b;
    logic        fwd_hit_b;
    logic [31:0] fwd_data_b;
    logic        idle;

    int checks = 0;
    int errors = 0;

    rf_wb_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .fwd_addr_a(fwd_addr_a), .fwd_hit_a(fwd_hit_a), .fwd_data_a(fwd_data_a),
        .fwd_addr_b(fwd_addr_b), .fwd_hit_b(fwd_hit_b), .fwd_data_b(fwd_data_b),
        .idle(idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [36:0] expq[$];
        logic [36:0] exp_w;
        logic        exp_wen;
        logic        exp_mr;
        logic        exp_ar;
        int          mi;
        int          ai;
        int          cyc;

        rst_n = 1'b0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        fwd_addr_a = '0; fwd_addr_b = '0;
        #12;
        check("rst_w_en", {31'b0, w_en}, 32'd0);
        check("rst_w_addr", {27'b0, w_addr}, 32'd0);
        check("rst_w_data", w_data, 32'd0);
        check("rst_idle", {31'b0, idle}, 32'd1);
        check("rst_mem_ready", {31'b0, mem_ready}, 32'd1);
        check("rst_alu_ready", {31'b0, alu_ready}, 32'd1);
        rst_n = 1'b1;
        #1;

        // Single ALU transfer
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_00AA;
        step();
        alu_valid = 1'b0;
        check("single_no_early_wen", {31'b0, w_en}, 32'd0);
        check("single_not_idle", {31'b0, idle}, 32'd0);
        step();
        check("single_wen", {31'b0, w_en}, 32'd1);
        check("single_waddr", {27'b0, w_addr}, 32'd5);
        check("single_wdata", w_data, 32'h0000_00AA);
        step();
        check("single_wen_off", {31'b0, w_en}, 32'd0);
        check("single_idle", {31'b0, idle}, 32'd1);
        check("single_waddr_hold", {27'b0, w_addr}, 32'd5);

        // Dual transfer to the same register
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h22;
        fwd_addr_a = 5'd3;
        #1;
        check("dual_mem_ready", {31'b0, mem_ready}, 32'd1);
        check("dual_alu_ready", {31'b0, alu_ready}, 32'd1);
        check("fwd_no_input_bypass", {31'b0, fwd_hit_a}, 32'd0);
        step();
        mem_valid = 1'b0; alu_valid = 1'b0;
`ifdef WB_FORWARD_EN
        check("fwd_both_hit", {31'b0, fwd_hit_a}, 32'd1);
        check("fwd_both_data", fwd_data_a, 32'h22);
`else
        check("nofwd_hit", {31'b0, fwd_hit_a}, 32'd0);
`endif
        step();
        check("dual_first_wen", {31'b0, w_en}, 32'd1);
        check("dual_first_data", w_data, 32'h11);
`ifdef WB_FORWARD_EN
        check("fwd_second_hit", {31'b0, fwd_hit_a}, 32'd1);
        check("fwd_second_data", fwd_data_a, 32'h22);
`endif
        step();
        check("dual_second_wen", {31'b0, w_en}, 32'd1);
        check("dual_second_addr", {27'b0, w_addr}, 32'd3);
        check("dual_second_data", w_data, 32'h22);
`ifdef WB_FORWARD_EN
        check("fwd_outreg_hit", {31'b0, fwd_hit_a}, 32'd1);
        check("fwd_outreg_data", fwd_data_a, 32'h22);
`endif
        step();
        check("dual_drained_wen", {31'b0, w_en}, 32'd0);
        check("dual_drained_idle", {31'b0, idle}, 32'd1);
        check("fwd_drained_hit", {31'b0, fwd_hit_a}, 32'd0);

        // Six back-to-back dual transfers against a reference FIFO model
        mi = 0; ai = 0; cyc = 0;
        while ((mi < 6 || ai < 6 || expq.size() > 0) && cyc < 60) begin
            mem_valid = (mi < 6); mem_rd = 5'(1 + mi);  mem_data = 32'h1000 + 32'(mi);
            alu_valid = (ai < 6); alu_rd = 5'(10 + ai); alu_data = 32'h2000 + 32'(ai);
            #1;
            exp_mr = (expq.size() <= 3);
            exp_ar = (expq.size() <= 2) || (!mem_valid && expq.size() <= 3);
            check("burst_mem_ready", {31'b0, mem_ready}, {31'b0, exp_mr});
            check("burst_alu_ready", {31'b0, alu_ready}, {31'b0, exp_ar});
            exp_wen = (expq.size() > 0);
            exp_w = '0;
            if (exp_wen) exp_w = expq.pop_front();
            if (mem_valid && exp_mr) begin
                expq.push_back({mem_rd, mem_data});
                mi++;
            end
            if (alu_valid && exp_ar) begin
                expq.push_back({alu_rd, alu_data});
                ai++;
            end
            step();
            cyc++;
            check("burst_wen", {31'b0, w_en}, {31'b0, exp_wen});
            if (exp_wen) begin
                check("burst_waddr", {27'b0, w_addr}, {27'b0, exp_w[36:32]});
                check("burst_wdata", w_data, exp_w[31:0]);
            end
        end
        mem_valid = 1'b0; alu_valid = 1'b0;
        step();
        check("burst_end_wen", {31'b0, w_en}, 32'd0);
        check("burst_end_idle", {31'b0, idle}, 32'd1);
        check("burst_last_addr", {27'b0, w_addr}, 32'd15);
        check("burst_last_data", w_data, 32'h2005);

        // rd=0 transfer is accepted but never written
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
        fwd_addr_a = 5'd0;
        #1;
        check("rd0_alu_ready", {31'b0, alu_ready}, 32'd1);
        check("rd0_fwd_hit", {31'b0, fwd_hit_a}, 32'd0);
        step();
        alu_valid = 1'b0;
        check("rd0_no_wen", {31'b0, w_en}, 32'd0);
        check("rd0_idle", {31'b0, idle}, 32'd1);
        step();
        check("rd0_no_wen_later", {31'b0, w_en}, 32'd0);

        // Fill three entries, then reset mid-cycle
        mem_valid = 1'b1; mem_rd = 5'd8;  mem_data = 32'h81;
        alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'h91;
        step();
        mem_rd = 5'd10; mem_data = 32'hA1;
        alu_rd = 5'd7;  alu_data = 32'h77;
        step();
        mem_valid = 1'b0; alu_valid = 1'b0;
        fwd_addr_a = 5'd7;
        #1;
        check("fill_wen", {31'b0, w_en}, 32'd1);
        check("fill_waddr", {27'b0, w_addr}, 32'd8);
        check("fill_alu_ready_gated", {31'b0, alu_ready}, 32'd1);
`ifdef WB_FORWARD_EN
        check("fwd_pending7_hit", {31'b0, fwd_hit_a}, 32'd1);
        check("fwd_pending7_data", fwd_data_a, 32'h77);
`else
        check("nofwd_pending7_hit", {31'b0, fwd_hit_a}, 32'd0);
        check("nofwd_pending7_data", fwd_data_a, 32'd0);
`endif
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_wen", {31'b0, w_en}, 32'd0);
        check("midrst_idle", {31'b0, idle}, 32'd1);
        check("midrst_waddr", {27'b0, w_addr}, 32'd0);
        check("midrst_wdata", w_data, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("postrst_no_wen", {31'b0, w_en}, 32'd0);
            check("postrst_idle", {31'b0, idle}, 32'd1);
        end
        check("postrst_fwd_hit", {31'b0, fwd_hit_a}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_queue.md
Name: rf_wb_queue

Overview:
- Write-back scheduler for the 32x32 register file's single write port; produces the file's w_en / w_addr / w_data.
- Accepts results from two producers, the ALU and the load unit, over valid/ready handshakes.
- Buffers results in a small in-order queue and retires one register write per clock.
- Optionally forwards not-yet-retired values to the operand-read stage, so reads never see stale data.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on the posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- mem_valid  in  1  load result present.
- mem_ready  out  1  queue can take the load result this cycle.
- mem_rd  in  5  load destination register.
- mem_data  in  32  load result.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  queue can take the ALU result this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- w_en  out  1  register-file write enable (registered).
- w_addr  out  5  register-file write address (registered).
- w_data  out  32  register-file write data (registered).
- fwd_addr_a  in  5  operand A lookup address.
- fwd_hit_a  out  1  operand A has a pending value.
- fwd_data_a  out  32  pending value for operand A.
- fwd_addr_b  in  5  operand B lookup address.
- fwd_hit_b  out  1  operand B has a pending value.
- fwd_data_b  out  32  pending value for operand B.
- idle  out  1  queue empty and w_en low.

Behaviour:
- Reset (async, rst_n low): queue empty (count=0, head=tail=0); w_en=0, w_addr=0, w_data=0; idle=1. Reset asserted mid-operation discards all queued entries; no partial write is emitted.
- Handshake: a transfer occurs on a posedge where valid and ready are both high. Producers hold rd/data stable while valid is high and ready is low.
- Ready rules, combinational from registered count and mem_valid; pops in the same cycle are not credited:
  - mem_ready = (count <= DEPTH-1).
  - alu_ready = (count <= DEPTH-2) or (!mem_valid and count <= DEPTH-1).
  - The load channel has fixed priority when one slot remains.
- Enqueue:
  - Both channels accepted in the same cycle: the load entry is written at tail and the ALU entry at tail+1, so the load entry is older.
  - A transfer with rd=0 is accepted (ready as above) but is not enqueued.
  - tail and head wrap modulo DEPTH.
- Retire: on each posedge,
  - if count>0, the head entry moves into w_addr/w_data with w_en=1, head advances, count decrements;
  - otherwise w_en=0 and w_addr/w_data hold their previous value.
  - An entry enqueued while count was 0 does not retire on the same edge.
- Latency: a transfer at edge N with an empty queue gives w_en=1 in the cycle after edge N+1. The register file writes it on that cycle's negedge. Sustained throughput is one write per clock.
- Count update: count_next = count + pushes - pop. Pushes are 0..2 and pop is 0..1; simultaneous push and pop at count=DEPTH-1 is legal. Overflow is impossible by the ready rules; underflow is impossible because pop requires count>0.
- idle = (count==0) and !w_en.

Optional Feature:
- Macro: WB_FORWARD_EN.
- Defined:
  - fwd_hit_x=1 when fwd_addr_x != 0 and fwd_addr_x matches w_addr (with w_en=1) or any valid queue entry.
  - fwd_data_x is the youngest match: queue entries from tail-1 back to head first, then the output register.
  - The lookup is purely combinational, with no same-cycle bypass from the mem/alu inputs.
- Undefined: fwd_hit_a/b=0 and fwd_data_a/b=0 constant; the fwd_addr inputs are ignored.

Test Plan:
- Reset, then single ALU transfer rd=5, data=0x0000_00AA at edge 1 -> w_en=1, w_addr=5, w_data=0xAA during cycle after edge 2; idle=1 after edge 3.
- mem (rd=3, 0x11) and alu (rd=3, 0x22) transferred same edge -> two writes on consecutive cycles, 0x11 then 0x22; with WB_FORWARD_EN, fwd_addr_a=3 gives 0x22 while both are pending and 0x22 once only the second remains.
- Hold w_en-driven drain blocked by issuing 6 back-to-back dual transfers (DEPTH=4) -> count never exceeds 4; alu_ready=0 whenever count=3 and mem_valid=1; writes retire in acceptance order with no loss or duplicate.
- ALU transfer with rd=0, data=0xFFFF_FFFF -> accepted (alu_ready=1), no w_en pulse; fwd_hit=0 for fwd_addr=0.
- Fill 3 entries, then assert rst_n low mid-cycle -> w_en=0, idle=1 immediately; after release, no stale writes appear.
- Build without WB_FORWARD_EN, with pending rd=7 -> fwd_hit_a=0 and fwd_data_a=0 for fwd_addr_a=7.
